musa_prog_loader: RTL

//  Hardware program loader for the MUSA core: the writer side of instruction memory.

---
 rtl/musa_pkg.sv | 25 ++
 rtl/musa_word_packer.sv | 55 +++++
 rtl/musa_prog_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/musa_pkg.sv
// ---------------------------------------------------------------------------
// musa_pkg
// Shared constants and types for the MUSA program loader.
//   DATA_WIDTH     : instruction word width (four stream bytes)
//   ADDR_WIDTH     : instruction memory word-address width
//   BYTE_W         : stream byte width
//   loader_state_t : loader FSM state encoding
// ---------------------------------------------------------------------------
package musa_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 10;
   localparam int BYTE_W     = 8;

   typedef enum logic [2:0] {
      IDLE,
      HDR_HI,
      HDR_LO,
      DATA,
      WRITE,
      DONE,
      ERR
   } loader_state_t;

endpackage

// File: rtl/musa_word_packer.sv
// ---------------------------------------------------------------------------
// musa_word_packer
// Assembles four stream bytes into one big-endian word. The first byte ends
// up in the most significant position after four shifts.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart assembly of a new word (clears data and count)
//   shift_en  : shift byte_in into the word this cycle
//   byte_in   : incoming stream byte
//   word_out  : word assembled so far
//   full      : this shift completes a word (fourth byte)
// ---------------------------------------------------------------------------
module musa_word_packer #(
   parameter int BYTE_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                shift_en,
   input  logic [BYTE_W-1:0]   byte_in,
   output logic [4*BYTE_W-1:0] word_out,
   output logic                full
);

   logic [4*BYTE_W-1:0] word_q, word_d;
   logic [1:0]          cnt_q, cnt_d;

   // Bytes enter at the bottom and move up, so the oldest byte lands in the
   // top lane. The counter wraps to zero on the fourth byte, ready for the
   // next word without an explicit clear.
   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clr) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (shift_en) begin
         word_d = {word_q[3*BYTE_W-1:0], byte_in};
         cnt_d  = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   assign word_out = word_q;
   assign full     = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/musa_prog_loader.sv
// ---------------------------------------------------------------------------
// musa_prog_loader
// Writer side of the MUSA instruction memory. Receives a byte stream (16-bit
// big-endian word count N, then N big-endian words), writes the words from
// address 0 upward and holds the core in reset until the image is complete.
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a load (honoured in IDLE/DONE/ERR only)
//   in_data     : stream byte, in_valid/in_ready handshake
//   imem_addr   : instruction memory write address
//   imem_wdata  : instruction word
//   imem_we     : one-cycle write strobe per word
//   core_rst    : reset for the core, released once the image is loaded
//   busy        : load in progress
//   done        : image loaded, core running
//   error       : header word count exceeds memory depth
// ---------------------------------------------------------------------------
module musa_prog_loader #(
   parameter int DATA_WIDTH = musa_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = musa_pkg::ADDR_WIDTH,
   parameter int BYTE_W     = musa_pkg::BYTE_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BYTE_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  imem_we,
   output logic                  core_rst,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   import musa_pkg::*;

   localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

   loader_state_t         state_q, state_d;
   logic [15:0]           n_q, n_d;
   logic [15:0]           words_q, words_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  in_ready_q, in_ready_d;
   logic                  imem_we_q, imem_we_d;
   logic                  core_rst_q, core_rst_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic                  xfer;
   logic                  pk_clr;
   logic                  pk_shift;
   logic                  pk_full;
   logic [15:0]           n_full;

   // in_ready is a flop, so the handshake never looks at in_valid
   // combinationally.
   assign xfer     = in_valid && in_ready_q;
   assign pk_shift = xfer && (state_q == DATA);
   assign n_full   = {n_q[15:8], in_data[7:0]};

   musa_word_packer #(
      .BYTE_W (BYTE_W)
   ) u_packer (
      .clk      (clk),
      .rst      (rst),
      .clr      (pk_clr),
      .shift_en (pk_shift),
      .byte_in  (in_data),
      .word_out (imem_wdata),
      .full     (pk_full)
   );

   // Next-state logic. All outputs are derived from the next state, so they
   // are registered yet already valid in the first cycle of each state
   // (e.g. core_rst drops the very cycle DONE is entered).
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      words_d = words_q;
      addr_d  = addr_q;
      pk_clr  = 1'b0;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = HDR_HI;
               n_d     = '0;
               words_d = '0;
               addr_d  = '0;
               pk_clr  = 1'b1;
            end
         end
         HDR_HI: begin
            if (xfer) begin
               n_d[15:8] = in_data[7:0];
               state_d   = HDR_LO;
            end
         end
         HDR_LO: begin
            if (xfer) begin
               n_d = n_full;
               if (n_full == 16'd0) begin
                  state_d = DONE;
               end else if ({1'b0, n_full} > MAX_WORDS) begin
                  state_d = ERR;
               end else begin
                  state_d = DATA;
                  pk_clr  = 1'b1;
               end
            end
         end
         DATA: begin
            if (pk_full) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            // A full-depth image wraps addr back to 0 here; that is only
            // visible in DONE, never as a write.
            addr_d  = addr_q + 1'b1;
            words_d = words_q + 16'd1;
            state_d = (words_d == n_q) ? DONE : DATA;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d = (state_d == HDR_HI) || (state_d == HDR_LO) || (state_d == DATA);
      imem_we_d  = (state_d == WRITE);
      busy_d     = (state_d == HDR_HI) || (state_d == HDR_LO) ||
                   (state_d == DATA)   || (state_d == WRITE);
      done_d     = (state_d == DONE);
      error_d    = (state_d == ERR);
      core_rst_d = (state_d != DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         n_q        <= '0;
         words_q    <= '0;
         addr_q     <= '0;
         in_ready_q <= 1'b0;
         imem_we_q  <= 1'b0;
         core_rst_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         words_q    <= words_d;
         addr_q     <= addr_d;
         in_ready_q <= in_ready_d;
         imem_we_q  <= imem_we_d;
         core_rst_q <= core_rst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign imem_addr = addr_q;
   assign imem_we   = imem_we_q;
   assign core_rst  = core_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule
